// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer retire path: FSM state, default tag
// width and the {tag, data} record carried by the output FIFO.
package rob_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

    typedef logic [ADDR_WIDTH_DEF-1:0] tag_t;

    typedef enum logic {
        FETCH = 1'b0,
        CHECK = 1'b1
    } retire_state_t;

    typedef struct packed {
        tag_t                      tag;
        logic [DATA_WIDTH_DEF-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_out_fifo.sv
// Two-entry output FIFO: push/full on the write side, valid/ready on the read
// side. A push and a pop in the same cycle leave the occupancy unchanged.
module rob_out_fifo
    import rob_pkg::*;
#(
    parameter type entry_t = rob_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    output logic   full,
    output logic   valid,
    input  logic   ready,
    output entry_t pop_data
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       pop;

    assign valid    = (count != 2'd0);
    assign full     = (count == 2'd2);
    assign pop      = valid & ready;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            // Stored words are left as-is; only occupancy matters once empty.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/rob_retire.sv
// In-order retire stage: polls the head entry of the valid/payload memories,
// moves valid entries into a 2-deep output FIFO and clears them in the ROB.
module rob_retire
    import rob_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] vld_addr_o,
    input  logic                  vld_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  clr_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_tag_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] head_o,
    output logic [CNT_WIDTH-1:0]  retired_cnt_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0] data;
    } out_entry_t;

    retire_state_t         state;
    logic [ADDR_WIDTH-1:0] head;
    logic [CNT_WIDTH-1:0]  retired_cnt;
    logic                  fifo_full;
    logic                  push;
    out_entry_t            push_entry;
    out_entry_t            pop_entry;

    // Fullness is sampled before any same-cycle pop, so a draining FIFO
    // still blocks the push; the head simply gets polled again.
    assign push       = (state == CHECK) && vld_i && !fifo_full && !flush_i;
    assign push_entry = '{tag: head, data: data_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            head        <= '0;
            retired_cnt <= '0;
        end else if (flush_i) begin
            state <= FETCH;
            head  <= '0;
        end else begin
            case (state)
                FETCH: state <= CHECK;
                CHECK: begin
                    state <= FETCH;
                    if (push) begin
                        head        <= head + 1'b1;
                        retired_cnt <= retired_cnt + 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    rob_out_fifo #(
        .entry_t (out_entry_t)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .push      (push),
        .push_data (push_entry),
        .full      (fifo_full),
        .valid     (out_valid_o),
        .ready     (out_ready_i),
        .pop_data  (pop_entry)
    );

    assign vld_addr_o    = head;
    assign data_addr_o   = head;
    assign clr_o         = push;
    assign clr_addr_o    = head;
    assign head_o        = head;
    assign retired_cnt_o = retired_cnt;
    assign out_tag_o     = pop_entry.tag;
    assign out_data_o    = pop_entry.data;

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: a behavioural ROB (allocate in order, complete in any
// order) feeds a scoreboard of expected retirements and clears.
module tb_rob_retire;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int NENT  = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] vld_addr, data_addr, clr_addr, out_tag, head;
    logic          vld_i, clr, flush, out_valid, out_ready;
    logic [DW-1:0] data_i, out_data;
    logic [CW-1:0] retired_cnt;

    rob_retire #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vld_addr_o    (vld_addr),
        .vld_i         (vld_i),
        .data_addr_o   (data_addr),
        .data_i        (data_i),
        .clr_o         (clr),
        .clr_addr_o    (clr_addr),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_tag_o     (out_tag),
        .out_data_o    (out_data),
        .head_o        (head),
        .retired_cnt_o (retired_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // External valid/payload memories with one-cycle read latency.
    logic          vld_mem [NENT];
    logic [DW-1:0] dat_mem [NENT];
    logic          comp_vld;
    logic [AW-1:0] comp_tag;
    logic [DW-1:0] comp_data;

    always @(posedge clk) begin
        vld_i  <= vld_mem[vld_addr];
        data_i <= dat_mem[data_addr];
        if (!rst_n || flush) begin
            for (int i = 0; i < NENT; i++) vld_mem[i] <= 1'b0;
        end else begin
            if (clr) vld_mem[clr_addr] <= 1'b0;
            if (comp_vld) begin
                vld_mem[comp_tag] <= 1'b1;
                dat_mem[comp_tag] <= comp_data;
            end
        end
    end

    // Scoreboard: retirement order equals allocation order.
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    clr_q[$];
    logic [AW-1:0]    pend_tag[$];
    logic [DW-1:0]    pend_dat[$];
    logic [AW-1:0]    alloc_ptr = '0;
    int               hs_total = 0;
    int               cyc = 0;
    int               last_hs = 0;
    int               gap_seen = 0;
    logic             gap_chk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("addr_match", {vld_addr, data_addr}, {head, head});
            if (flush) begin
                chk("flush_no_clr", clr, 1'b0);
                exp_q.delete();
                clr_q.delete();
            end else begin
                if (clr) begin
                    if (clr_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL clr_unexpected: got clear of %0d, expected none", clr_addr);
                    end else chk("clr_addr", clr_addr, clr_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL out_unexpected: got tag %0d, expected none", out_tag);
                    end else chk("out_tag_data", {out_tag, out_data}, exp_q.pop_front());
                    hs_total++;
                    if (gap_chk) begin
                        if (gap_seen > 0) chk("retire_gap", cyc - last_hs, 2);
                        gap_seen++;
                    end
                    last_hs = cyc;
                end
            end
            if (!gap_chk) gap_seen = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        comp_vld = 1'b0;
    endtask

    task automatic alloc(input logic [DW-1:0] d);
        exp_q.push_back({alloc_ptr, d});
        clr_q.push_back(alloc_ptr);
        pend_tag.push_back(alloc_ptr);
        pend_dat.push_back(d);
        alloc_ptr++;
    endtask

    // Marks a pending entry valid at the next clock edge.
    task automatic complete_idx(input int i);
        comp_vld  = 1'b1;
        comp_tag  = pend_tag[i];
        comp_data = pend_dat[i];
        pend_tag.delete(i);
        pend_dat.delete(i);
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int n = 0;
        while ((exp_q.size() != 0) && (n < lim)) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got %0d items left, expected 0", nm, exp_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        comp_vld  = 1'b0;
        comp_tag  = '0;
        comp_data = '0;
        #12;
        chk("rst_head", head, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_clr", {clr, clr_addr}, 0);
        chk("rst_addr", {vld_addr, data_addr}, 0);
        chk("rst_out", {out_tag, out_data}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle polling with nothing valid.
        repeat (10) step();
        chk("idle_head", head, 0);
        chk("idle_valid", out_valid, 0);

        // Three consecutive valid entries with a free-flowing output.
        out_ready = 1'b1;
        gap_chk   = 1'b1;
        for (int i = 0; i < 3; i++) alloc(32'hA0 + i);
        for (int i = 0; i < 3; i++) begin
            complete_idx(0);
            step();
        end
        wait_drain("seq3", 40);
        repeat (3) step();
        gap_chk = 1'b0;
        chk("seq3_head", head, 3);
        chk("seq3_cnt", retired_cnt, 3);

        // Out-of-order completion under backpressure, then flush.
        out_ready = 1'b0;
        alloc(32'h1234_0003);
        alloc(32'h1234_0004);
        complete_idx(1);
        step();
        repeat (12) step();
        chk("ooo_head_wait", head, 3);
        chk("ooo_no_valid", out_valid, 0);
        complete_idx(0);
        step();
        repeat (10) step();
        chk("ooo_head", head, 5);
        chk("ooo_valid", out_valid, 1);
        chk("ooo_cnt", retired_cnt, 5);
        chk("ooo_front_tag", out_tag, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        pend_tag.delete();
        pend_dat.delete();
        alloc_ptr = '0;
        chk("flush_valid", out_valid, 0);
        chk("flush_head", head, 0);
        chk("flush_cnt", retired_cnt, 5);

        // Backpressure: only two entries leave the ROB until ready rises.
        for (int i = 0; i < 4; i++) alloc(32'hB0 + i);
        for (int i = 0; i < 4; i++) begin
            complete_idx(0);
            step();
        end
        repeat (20) step();
        chk("bp_head", head, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_cnt", retired_cnt, 7);
        out_ready = 1'b1;
        wait_drain("bp", 40);
        chk("bp_head_end", head, 4);
        chk("bp_cnt_end", retired_cnt, 9);

        // Random allocation/completion/ready traffic with head wrap-around.
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ((clr_q.size() < NENT) && ($urandom_range(0, 2) == 0)) alloc($urandom);
            if ((pend_tag.size() != 0) && ($urandom_range(0, 1) == 0))
                complete_idx($urandom_range(0, pend_tag.size() - 1));
            step();
        end
        out_ready = 1'b1;
        while (pend_tag.size() != 0) begin
            complete_idx(0);
            step();
        end
        wait_drain("rand", 400);
        repeat (4) step();
        chk("rand_head", head, alloc_ptr);
        chk("rand_cnt", retired_cnt, hs_total + 2);
        chk("rand_idle_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
